// File: rtl/atm_pin_session_pkg.sv
// Shared definitions for the ATM PIN session controller and its neighbours.
// The PIN_DIGITS/MAX_TRIES defaults are also used by the transaction FSM, so
// both blocks agree on PIN length and retry budget.
package atm_pkg;

    localparam int DIGIT_W        = 4;
    localparam int BCD_MAX        = 9;
    localparam int PIN_DIGITS_DEF = 4;
    localparam int MAX_TRIES_DEF  = 3;
    localparam int TRIES_W        = 3;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_ABORT
    } state_t;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/atm_pin_session_if.sv
// Handshake bundle between the keypad/card front end, the inactivity timer
// and the PIN session controller.
//   slave  : session controller (consumes keys/timeout, drives pulses/status)
//   master : front end / testbench (drives keys, card, pin_ref, timeout)
interface atm_pin_session_if
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = PIN_DIGITS_DEF
) ();

    logic                          card_in;
    logic                          key_valid;
    logic [DIGIT_W-1:0]            key_digit;
    logic                          key_enter;
    logic                          key_cancel;
    logic [DIGIT_W*PIN_DIGITS-1:0] pin_ref;
    logic                          timer_timeout;
    logic                          timer_restart;
    logic                          pin_ok;
    logic                          pin_bad;
    logic                          card_retain;
    logic                          session_abort;
    logic                          busy;
    logic [CNT_W-1:0]              digit_count;

    modport slave (
        input  card_in, key_valid, key_digit, key_enter, key_cancel,
               pin_ref, timer_timeout,
        output timer_restart, pin_ok, pin_bad, card_retain, session_abort,
               busy, digit_count
    );

    modport master (
        output card_in, key_valid, key_digit, key_enter, key_cancel,
               pin_ref, timer_timeout,
        input  timer_restart, pin_ok, pin_bad, card_retain, session_abort,
               busy, digit_count
    );

endinterface

// File: rtl/atm_pin_session_buffer.sv
// pin_digit_buffer: holds the entered PIN digits and the fill count, and
// compares the whole buffer against the reference PIN.
//   clk, rst    : clock, async active-high reset
//   clear       : empty the buffer (wins over load)
//   load, digit : append digit at index digit_count when not full
//   pin_ref     : reference PIN, digit 0 in the low nibble
//   digit_count : digits held (saturates at PIN_DIGITS)
//   match       : all nibbles equal pin_ref (combinational)
module pin_digit_buffer
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = PIN_DIGITS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          load,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic [DIGIT_W*PIN_DIGITS-1:0] pin_ref,
    output logic [CNT_W-1:0]              digit_count,
    output logic                          match
);

    logic                  full;
    logic [PIN_DIGITS-1:0] eq;

    assign full  = (digit_count == CNT_W'(PIN_DIGITS));
    assign match = &eq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_count <= '0;
        end else if (clear) begin
            digit_count <= '0;
        end else if (load && !full) begin
            digit_count <= digit_count + CNT_W'(1);
        end
    end

    // One register per digit position; a slot loads when the fill count
    // points at it.
    for (genvar g = 0; g < PIN_DIGITS; g++) begin : g_dig
        logic [DIGIT_W-1:0] d_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                d_q <= '0;
            end else if (clear) begin
                d_q <= '0;
            end else if (load && digit_count == CNT_W'(g)) begin
                d_q <= digit;
            end
        end

        assign eq[g] = (d_q == pin_ref[g*DIGIT_W +: DIGIT_W]);
    end

endmodule

// File: rtl/atm_pin_session.sv
// atm_pin_session: card-insert -> PIN entry -> verify -> grant/retry/retain
// session controller. Restarts the external inactivity timer on every
// accepted key and aborts the session on timer expiry or CANCEL.
//   clk, rst : clock, async active-high reset
//   bus      : atm_pin_session_if.slave (keys, card, pin_ref, timer
//              handshake, result pulses, busy, digit_count)
// All outputs are registered.
module atm_pin_session
    import atm_pkg::*;
#(
    parameter int PIN_DIGITS = PIN_DIGITS_DEF,
    parameter int MAX_TRIES  = MAX_TRIES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    atm_pin_session_if.slave  bus
);

    state_t               state_q, state_d;
    logic [TRIES_W-1:0]   tries_q, tries_d;
    logic                 buf_clear, buf_load, match;
    logic [CNT_W-1:0]     cnt;
    logic                 restart_d, ok_d, bad_d, retain_d, abort_d;
    logic                 restart_q, ok_q, bad_q, retain_q, abort_q, busy_q;

    pin_digit_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_buf (
        .clk         (clk),
        .rst         (rst),
        .clear       (buf_clear),
        .load        (buf_load),
        .digit       (bus.key_digit),
        .pin_ref     (bus.pin_ref),
        .digit_count (cnt),
        .match       (match)
    );

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        buf_clear = 1'b0;
        buf_load  = 1'b0;
        restart_d = 1'b0;
        ok_d      = 1'b0;
        bad_d     = 1'b0;
        retain_d  = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.card_in) begin
                    buf_clear = 1'b1;
                    tries_d   = '0;
                    restart_d = 1'b1;
                    state_d   = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Only the highest-priority event acts: timeout > cancel >
                // enter > digit. A timeout therefore drops a same-cycle key.
                if (bus.timer_timeout || bus.key_cancel) begin
                    state_d = S_ABORT;
                end else if (bus.key_enter) begin
                    if (cnt == CNT_W'(PIN_DIGITS)) state_d   = S_CHECK;
                    else                           restart_d = 1'b1;
                end else if (bus.key_valid) begin
                    if (is_bcd(bus.key_digit) && cnt != CNT_W'(PIN_DIGITS)) begin
                        buf_load  = 1'b1;
                        restart_d = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (match) begin
                    ok_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (tries_q + TRIES_W'(1) == TRIES_W'(MAX_TRIES)) begin
                    retain_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tries_d   = tries_q + TRIES_W'(1);
                    bad_d     = 1'b1;
                    buf_clear = 1'b1;
                    restart_d = 1'b1;
                    state_d   = S_COLLECT;
                end
            end
            S_ABORT: begin
                abort_d   = 1'b1;
                buf_clear = 1'b1;
                tries_d   = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tries_q   <= '0;
            restart_q <= 1'b0;
            ok_q      <= 1'b0;
            bad_q     <= 1'b0;
            retain_q  <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tries_q   <= tries_d;
            restart_q <= restart_d;
            ok_q      <= ok_d;
            bad_q     <= bad_d;
            retain_q  <= retain_d;
            abort_q   <= abort_d;
            // busy stays up through the terminal result pulse so the
            // transaction FSM sees the outcome while the session is still
            // flagged active; it drops the cycle after.
            busy_q    <= (state_d != S_IDLE) | ok_d | retain_d | abort_d;
        end
    end

    assign bus.timer_restart = restart_q;
    assign bus.pin_ok        = ok_q;
    assign bus.pin_bad       = bad_q;
    assign bus.card_retain   = retain_q;
    assign bus.session_abort = abort_q;
    assign bus.busy          = busy_q;
    assign bus.digit_count   = cnt;

endmodule

// File: tb/tb_atm_pin_session.sv
// Scoreboard bench for atm_pin_session: each stimulus pushes the expected
// output vector for the cycles it affects; a negedge monitor pops and
// compares entries whose cycle has arrived.
module tb_atm_pin_session;
    import atm_pkg::*;

    localparam int PD = 4;
    localparam int MT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    atm_pin_session_if #(.PIN_DIGITS(PD)) bus ();

    atm_pin_session #(.PIN_DIGITS(PD), .MAX_TRIES(MT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (rst,ok,bad,ret,abt,busy,cnt)", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {22'd0, bus.timer_restart, bus.pin_ok, bus.pin_bad, bus.card_retain,
                bus.session_abort, bus.busy, bus.digit_count};
    endfunction

    // expected outputs k cycles after the cycle in which this is called
    task automatic expv(input string tag, input int k, input bit r, input bit ok,
                        input bit bad, input bit ret, input bit ab, input bit bsy,
                        input int cnt);
        exp_t e;
        e.cyc = cyc + k;
        e.tag = tag;
        e.val = {22'd0, r, ok, bad, ret, ab, bsy, 4'(cnt)};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                chk(q[i].tag, obs(), q[i].val);
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                chk({q[i].tag, "_missed"}, 32'(q[i].cyc), 32'(cyc));
                q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic card();
        expv("card", 1, 1, 0, 0, 0, 0, 1, 0);
        bus.card_in = 1'b1;
        tick();
        bus.card_in = 1'b0;
    endtask

    task automatic enter();
        bus.key_enter = 1'b1;
        tick();
        bus.key_enter = 1'b0;
    endtask

    task automatic zeros();
        for (int i = 0; i < PD; i++) begin
            expv($sformatf("zkey%0d", i), 1, 1, 0, 0, 0, 0, 1, i + 1);
            press(4'd0);
        end
    endtask

    // one wrong attempt ending in pin_bad (last=0) or card_retain (last=1)
    task automatic wrong(input bit last);
        zeros();
        expv("chk_st", 1, 0, 0, 0, 0, 0, 1, PD);
        if (!last) begin
            expv("pin_bad", 2, 1, 0, 1, 0, 0, 1, 0);
            enter();
            tick();
        end else begin
            expv("retain", 2, 0, 0, 0, 1, 0, 1, PD);
            expv("retain_idle", 3, 0, 0, 0, 0, 0, 0, PD);
            enter();
            tick();
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.card_in       = 1'b0;
        bus.key_valid     = 1'b0;
        bus.key_digit     = '0;
        bus.key_enter     = 1'b0;
        bus.key_cancel    = 1'b0;
        bus.timer_timeout = 1'b0;
        bus.pin_ref       = 16'h4321;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        expv("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // correct PIN 1,2,3,4
        card();
        for (int i = 1; i <= 4; i++) begin
            expv($sformatf("key%0d", i), 1, 1, 0, 0, 0, 0, 1, i);
            press(4'(i));
        end
        expv("ok_chk", 1, 0, 0, 0, 0, 0, 1, 4);
        expv("pin_ok", 2, 0, 1, 0, 0, 0, 1, 4);
        expv("ok_idle", 3, 0, 0, 0, 0, 0, 0, 4);
        enter();
        tick();
        tick();
        tick();

        // three wrong PINs -> bad, bad, retain
        card();
        wrong(1'b0);
        wrong(1'b0);
        wrong(1'b1);

        // timeout after two digits, then a key while idle
        card();
        expv("to_k1", 1, 1, 0, 0, 0, 0, 1, 1);
        press(4'd1);
        expv("to_k2", 1, 1, 0, 0, 0, 0, 1, 2);
        press(4'd2);
        expv("to_abort_st", 1, 0, 0, 0, 0, 0, 1, 2);
        expv("to_abort", 2, 0, 0, 0, 0, 1, 1, 0);
        expv("to_idle", 3, 0, 0, 0, 0, 0, 0, 0);
        bus.timer_timeout = 1'b1;
        tick();
        bus.timer_timeout = 1'b0;
        tick();
        tick();
        expv("idle_key", 1, 0, 0, 0, 0, 0, 0, 0);
        press(4'd7);
        tick();

        // timeout coincident with a valid key
        card();
        expv("race_k", 1, 1, 0, 0, 0, 0, 1, 1);
        press(4'd5);
        expv("race_st", 1, 0, 0, 0, 0, 0, 1, 1);
        expv("race_abort", 2, 0, 0, 0, 0, 1, 1, 0);
        bus.timer_timeout = 1'b1;
        bus.key_valid     = 1'b1;
        bus.key_digit     = 4'd7;
        tick();
        bus.timer_timeout = 1'b0;
        bus.key_valid     = 1'b0;
        tick();
        tick();

        // edge inputs: non-BCD, short ENTER, card while busy, 5th digit, cancel
        card();
        for (int i = 1; i <= 3; i++) begin
            expv($sformatf("e_key%0d", i), 1, 1, 0, 0, 0, 0, 1, i);
            press(4'(i));
        end
        begin
            logic [3:0] bad_d;
            bad_d = 4'hA;
            expv("digit_A", 1, 0, 0, 0, 0, 0, 1, 3);
            press(bad_d);
        end
        expv("short_enter", 1, 1, 0, 0, 0, 0, 1, 3);
        enter();
        expv("card_busy", 1, 0, 0, 0, 0, 0, 1, 3);
        bus.card_in = 1'b1;
        tick();
        bus.card_in = 1'b0;
        expv("e_key4", 1, 1, 0, 0, 0, 0, 1, 4);
        press(4'd4);
        expv("fifth", 1, 0, 0, 0, 0, 0, 1, 4);
        press(4'd5);
        expv("cxl_st", 1, 0, 0, 0, 0, 0, 1, 4);
        expv("cxl_abort", 2, 0, 0, 0, 0, 1, 1, 0);
        expv("cxl_idle", 3, 0, 0, 0, 0, 0, 0, 0);
        bus.key_cancel = 1'b1;
        tick();
        bus.key_cancel = 1'b0;
        tick();
        tick();

        // reset during the CHECK of the third wrong attempt
        card();
        wrong(1'b0);
        wrong(1'b0);
        zeros();
        enter();
        rst = 1'b1;
        expv("rst_chk", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        // fresh session: tries back to 0, so two more pin_bad before retain
        card();
        wrong(1'b0);
        wrong(1'b0);
        wrong(1'b1);

        begin
            int w;
            w = 0;
            while (q.size() > 0 && w < 50) begin
                tick();
                w++;
            end
            chk("drain", 32'(q.size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
